dmem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port data RAM at the MEM stage. It shares the RAM between the pipeline's MEM-stage access and a DMA/loader port that issues fixed-length word bursts. The CPU has priority. DMA bursts are non-preemptible, and the CPU is stalled while a burst runs. A starvation counter guarantees that a pending DMA request is eventually accepted. The block sits between the MEM-stage access signals and DataRAM, which has asynchronous read and negedge write.

---
 rtl/dmem_arb_pkg.sv | 10 +
 rtl/dmem_burst_ctr.sv | 46 ++++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data RAM arbiter
package dmem_arb_pkg;

  typedef enum logic {IDLE, BURST} state_t;

  localparam int BEAT_BYTES       = 4;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_STARVE_LIMIT = 8;

endpackage

// File: rtl/dmem_burst_ctr.sv
// rtl/dmem_burst_ctr.sv - burst base/len latch, beat counter and wrapping address generator
module dmem_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              we_in,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              we
);

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      len_q    <= '0;
      we       <= 1'b0;
      beat_cnt <= '0;
    end else if (load) begin
      base_q   <= base_in & WORD_MASK;
      len_q    <= len_in;
      we       <= we_in;
      beat_cnt <= '0;
    end else if (run) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  // Address arithmetic is ADDR_W wide, so a burst crossing the top of memory wraps to 0.
  assign addr = base_q + ADDR_W'(beat_cnt) * ADDR_W'(BEAT_BYTES);
  assign last = (beat_cnt == len_q);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - MEM-stage / DMA arbiter for the single-port data RAM
// CPU has priority; DMA bursts are non-preemptible and a starvation counter forces DMA in.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_stall,
  input  logic                         dma_req,
  input  logic                         dma_we,
  input  logic [ADDR_W-1:0]            dma_addr,
  input  logic [$clog2(MAX_BURST)-1:0] dma_len,
  input  logic [DATA_W-1:0]            dma_wdata,
  output logic                         dma_ack,
  output logic                         dma_busy,
  output logic                         dma_wready,
  output logic                         dma_rvalid,
  output logic [DATA_W-1:0]            dma_rdata,
  output logic                         dma_done,
  output logic                         ram_we,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic [DATA_W-1:0]            ram_din,
  input  logic [DATA_W-1:0]            ram_dout
);

  localparam int LEN_W = $clog2(MAX_BURST);
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t            state;
  logic [SW-1:0]     starve_cnt;
  logic              accept;
  logic [ADDR_W-1:0] burst_addr;
  logic              burst_last;
  logic              burst_we;

  assign accept = !Reset && (state == IDLE) && dma_req
                  && (!cpu_req || (starve_cnt == STARVE_MAX));

  dmem_burst_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst_ctr (
    .clk     (Clk),
    .rst     (Reset),
    .load    (accept),
    .run     (state == BURST),
    .base_in (dma_addr),
    .len_in  (dma_len),
    .we_in   (dma_we),
    .addr    (burst_addr),
    .last    (burst_last),
    .we      (burst_we)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= BURST;
            starve_cnt <= '0;
          end else if (!dma_req) begin
            starve_cnt <= '0;
          end else if (cpu_req && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
        BURST: begin
          if (burst_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dma_ack  = accept;
  assign dma_busy = (state == BURST);

  // Every RAM-facing and data output is forced to 0 while Reset is held.
  always_comb begin
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    cpu_rdata  = '0;
    cpu_stall  = 1'b0;
    dma_wready = 1'b0;
    dma_rvalid = 1'b0;
    dma_rdata  = '0;
    dma_done   = 1'b0;
    if (!Reset) begin
      if (state == BURST) begin
        ram_we     = burst_we;
        ram_addr   = burst_addr;
        ram_din    = burst_we ? dma_wdata : '0;
        cpu_stall  = cpu_req;
        dma_wready = burst_we;
        dma_rvalid = !burst_we;
        dma_rdata  = burst_we ? '0 : ram_dout;
        dma_done   = burst_last;
      end else begin
        ram_we    = cpu_req & cpu_we;
        ram_addr  = cpu_addr;
        ram_din   = cpu_wdata;
        cpu_rdata = ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        Clk, Reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_len;
  logic        dma_ack, dma_busy, dma_wready, dma_rvalid, dma_done;
  logic        ram_we;
  logic [31:0] ram_addr, ram_din, ram_dout;

  dmem_arbiter dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_len    (dma_len),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_busy   (dma_busy),
    .dma_wready (dma_wready),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .dma_done   (dma_done),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // DataRAM model: asynchronous read, negedge write, 256 words indexed by addr[9:2].
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[254] = 32'hA5A50000;
    mem[255] = 32'hA5A50001;
    mem[0]   = 32'hA5A50002;
    mem[1]   = 32'hA5A50003;
  end
  always @(negedge Clk) if (ram_we) mem[ram_addr[9:2]] <= ram_din;
  assign ram_dout = mem[ram_addr[9:2]];

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t sb[$];
  beat_t mon_b;

  task automatic push_beat(input logic [31:0] a, input logic w, input logic [31:0] d, input logic l);
    beat_t b;
    b.addr = a; b.we = w; b.data = d; b.last = l;
    sb.push_back(b);
  endtask

  // Beat monitor: every DMA beat the DUT produces is matched against the scoreboard.
  always @(posedge Clk) begin
    #4;
    if (dma_wready || dma_rvalid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got addr %h expected no beat at %0t", ram_addr, $time);
      end else begin
        mon_b = sb.pop_front();
        check("beat_addr", ram_addr, mon_b.addr);
        check("beat_we", {31'b0, ram_we}, {31'b0, mon_b.we});
        check("beat_data", mon_b.we ? ram_din : dma_rdata, mon_b.data);
        check("beat_done", {31'b0, dma_done}, {31'b0, mon_b.last});
      end
    end
    if (dma_done) done_cnt++;
  end

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dma_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_din;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vt[7];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 1'b0, 32'h40, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[2] = '{1'b1, 1'b1, 32'h44, 32'h12345678, 1'b0, 1'b1, 32'h44, 32'h12345678, 1'b0, 32'h0};
    vt[3] = '{1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 1'b0, 32'h44, 32'h0,        1'b1, 32'h12345678};
    vt[4] = '{1'b0, 1'b1, 32'h80, 32'hFFFF0000, 1'b0, 1'b0, 32'h80, 32'hFFFF0000, 1'b0, 32'h0};
    vt[5] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b1, 1'b0, 32'h40, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[6] = '{1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 1'b0, 32'h44, 32'h0,        1'b1, 32'h12345678};

    // Reset: everything quiet even with live requests on the inputs
    Reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h11111111;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_len = 4'd3; dma_wdata = 32'h22222222;
    #2;
    check("rst_ram_we", {31'b0, ram_we}, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_din", ram_din, 32'h0);
    check("rst_ack", {31'b0, dma_ack}, 32'h0);
    check("rst_busy", {31'b0, dma_busy}, 32'h0);
    check("rst_stall", {31'b0, cpu_stall}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    step();
    cpu_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_len = 4'd0;
    step();
    Reset = 1'b0;

    // CPU-only traffic through the vector table
    for (int i = 0; i < 7; i++) begin
      step();
      cpu_req = vt[i].cpu_req; cpu_we = vt[i].cpu_we;
      cpu_addr = vt[i].cpu_addr; cpu_wdata = vt[i].cpu_wdata; dma_req = vt[i].dma_req;
      #3;
      check("vec_ram_we", {31'b0, ram_we}, {31'b0, vt[i].exp_we});
      check("vec_ram_addr", ram_addr, vt[i].exp_addr);
      check("vec_ram_din", ram_din, vt[i].exp_din);
      check("vec_stall", {31'b0, cpu_stall}, 32'h0);
      check("vec_ack", {31'b0, dma_ack}, 32'h0);
      if (vt[i].chk_rd) check("vec_cpu_rdata", cpu_rdata, vt[i].exp_rd);
    end

    // Idle DMA write burst of 4 beats at 0x100
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_len = 4'd3;
    #3;
    check("wr_ack", {31'b0, dma_ack}, 32'h1);
    for (int b = 0; b < 4; b++) push_beat(32'h100 + 32'(4 * b), 1'b1, 32'hC0DE0000 + 32'(b), b == 3);
    for (int b = 0; b < 4; b++) begin
      step();
      dma_req = 1'b0; dma_wdata = 32'hC0DE0000 + 32'(b);
      #3;
      check("wr_busy", {31'b0, dma_busy}, 32'h1);
    end
    step();
    #3;
    check("wr_idle", {31'b0, dma_busy}, 32'h0);
    for (int b = 0; b < 4; b++) begin
      step();
      cpu_req = 1'b1; cpu_addr = 32'h100 + 32'(4 * b);
      #3;
      check("wr_readback", cpu_rdata, 32'hC0DE0000 + 32'(b));
    end

    // Contention: CPU holds the RAM, DMA forced in on the 9th cycle
    cpu_addr = 32'h40;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100; dma_len = 4'd1;
      end
      #3;
      check("cont_ack", {31'b0, dma_ack}, {31'b0, c == 9});
      check("cont_stall", {31'b0, cpu_stall}, 32'h0);
    end
    push_beat(32'h100, 1'b0, 32'hC0DE0000, 1'b0);
    push_beat(32'h104, 1'b0, 32'hC0DE0001, 1'b1);
    for (int c = 0; c < 2; c++) begin
      step();
      dma_req = 1'b0;
      #3;
      check("cont_burst_stall", {31'b0, cpu_stall}, 32'h1);
    end
    step();
    #3;
    check("cont_release_stall", {31'b0, cpu_stall}, 32'h0);
    check("cont_release_busy", {31'b0, dma_busy}, 32'h0);
    check("cont_release_rdata", cpu_rdata, 32'hDEADBEEF);

    // Address wrap across the top of memory
    step();
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'hFFFFFFF8; dma_len = 4'd3;
    #3;
    check("wrap_ack", {31'b0, dma_ack}, 32'h1);
    push_beat(32'hFFFFFFF8, 1'b0, 32'hA5A50000, 1'b0);
    push_beat(32'hFFFFFFFC, 1'b0, 32'hA5A50001, 1'b0);
    push_beat(32'h00000000, 1'b0, 32'hA5A50002, 1'b0);
    push_beat(32'h00000004, 1'b0, 32'hA5A50003, 1'b1);
    for (int b = 0; b < 4; b++) begin
      step();
      dma_req = 1'b0;
    end
    step();
    #3;
    check("wrap_idle", {31'b0, dma_busy}, 32'h0);

    // Reset during beat 2 of an 8-beat write
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h200; dma_len = 4'd7; dma_wdata = 32'hBEEF0000;
    #3;
    check("rstb_ack", {31'b0, dma_ack}, 32'h1);
    push_beat(32'h200, 1'b1, 32'hBEEF0000, 1'b0);
    push_beat(32'h204, 1'b1, 32'hBEEF0001, 1'b0);
    for (int b = 0; b < 2; b++) begin
      step();
      dma_req = 1'b0; dma_wdata = 32'hBEEF0000 + 32'(b);
    end
    step();
    Reset = 1'b1; dma_wdata = 32'hBEEF0002;
    #1;
    check("rstb_busy", {31'b0, dma_busy}, 32'h0);
    check("rstb_wready", {31'b0, dma_wready}, 32'h0);
    check("rstb_done", {31'b0, dma_done}, 32'h0);
    check("rstb_ram_we", {31'b0, ram_we}, 32'h0);
    check("rstb_ram_addr", ram_addr, 32'h0);
    check("rstb_ram_din", ram_din, 32'h0);
    step();
    step();
    Reset = 1'b0;
    for (int i = 0; i < 8; i++)
      check("rstb_mem", mem[128 + i], (i < 2) ? 32'hBEEF0000 + 32'(i) : 32'h0);

    // One-beat read with the CPU waiting during the burst
    step();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40; dma_len = 4'd0;
    #3;
    check("len0_ack", {31'b0, dma_ack}, 32'h1);
    push_beat(32'h40, 1'b0, 32'hDEADBEEF, 1'b1);
    step();
    dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
    #3;
    check("len0_stall", {31'b0, cpu_stall}, 32'h1);
    check("len0_rvalid", {31'b0, dma_rvalid}, 32'h1);
    check("len0_done", {31'b0, dma_done}, 32'h1);
    step();
    #3;
    check("len0_stall_end", {31'b0, cpu_stall}, 32'h0);
    check("len0_cpu_rdata", cpu_rdata, 32'h12345678);

    step();
    cpu_req = 1'b0;
    step();
    check("sb_empty", sb.size(), 32'h0);
    check("done_count", done_cnt, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
